// File: rtl/sp_readout_pkg.sv
// Shared widths, out_data field offsets and helpers for the
// super-pixel readout blocks.
package sp_readout_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    localparam int N_PIX_DEF  = 8;
    localparam int TOA_W_DEF  = 9;
    localparam int FTOA_W_DEF = 5;
    localparam int TOT_W_DEF  = 8;
    localparam int COL_AW_DEF = 1;
    localparam int DEPTH_DEF  = 4;

    // out_data layout, LSB first: col, pix, tot, ftoa, toa
    localparam int COL_LSB_DEF  = 0;
    localparam int PIX_LSB_DEF  = COL_LSB_DEF + COL_AW_DEF;
    localparam int TOT_LSB_DEF  = PIX_LSB_DEF + clog2(N_PIX_DEF);
    localparam int FTOA_LSB_DEF = TOT_LSB_DEF + TOT_W_DEF;
    localparam int TOA_LSB_DEF  = FTOA_LSB_DEF + FTOA_W_DEF;
    localparam int DATA_W_DEF   = TOA_LSB_DEF + TOA_W_DEF;

endpackage

// File: rtl/sp_sync_fifo.sv
// Synchronous FIFO with occupancy count; overflow and underflow
// requests are ignored.
module sp_sync_fifo
    import sp_readout_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int AW    = clog2(DEPTH),
    localparam int LVL_W = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              do_wr, do_rd;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem[rd_ptr_q];

    always_comb begin
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_wr);
        rd_ptr_d = rd_ptr_q + AW'(do_rd);
        level_d  = level_q + LVL_W'(do_wr) - LVL_W'(do_rd);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/sp_hit_arbiter_fifo.sv
// Super-pixel readout: per-pixel hit capture, round-robin arbitration
// into a local FIFO, fair merge with the upstream column chain.
module sp_hit_arbiter_fifo
    import sp_readout_pkg::*;
#(
    parameter int N_PIX        = N_PIX_DEF,
    parameter int TOA_W        = TOA_W_DEF,
    parameter int FTOA_W       = FTOA_W_DEF,
    parameter int TOT_W        = TOT_W_DEF,
    parameter int COL_AW       = COL_AW_DEF,
    parameter int DEPTH        = DEPTH_DEF,
    parameter int TOA_GRAY_DEC = 1,
    localparam int PIX_AW      = clog2(N_PIX),
    localparam int DATA_W      = TOA_W + FTOA_W + TOT_W + PIX_AW + COL_AW,
    localparam int LVL_W       = clog2(DEPTH) + 1
) (
    input  logic                      clk_40MHz,
    input  logic                      rst,
    input  logic                      en,
    input  logic [N_PIX-1:0]          hit_valid,
    input  logic [N_PIX*TOA_W-1:0]    hit_toa,
    input  logic [N_PIX*FTOA_W-1:0]   hit_ftoa,
    input  logic [N_PIX*TOT_W-1:0]    hit_tot,
    input  logic [COL_AW-1:0]         col_addr,
    input  logic [DATA_W-1:0]         last_data,
    input  logic                      last_valid,
    output logic                      last_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LVL_W-1:0]          fifo_level,
    output logic [7:0]                ovf_cnt,
    output logic                      busy
);

    logic [N_PIX-1:0]  pend_q, pend_d;
    logic [TOA_W-1:0]  toa_q  [N_PIX];
    logic [TOA_W-1:0]  toa_d  [N_PIX];
    logic [FTOA_W-1:0] ftoa_q [N_PIX];
    logic [FTOA_W-1:0] ftoa_d [N_PIX];
    logic [TOT_W-1:0]  tot_q  [N_PIX];
    logic [TOT_W-1:0]  tot_d  [N_PIX];
    logic [PIX_AW-1:0] rr_q, rr_d;
    logic [7:0]        ovf_q, ovf_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              prio_loc_q, prio_loc_d;

    logic              fifo_full, fifo_empty;
    logic              fifo_wr, fifo_rd;
    logic [DATA_W-1:0] fifo_wdata, fifo_rdata;

    logic              gnt_any;
    logic [PIX_AW-1:0] gnt_idx, idx;
    logic [15:0]       ndrop, ovf_sum;
    logic              load_en, sel_loc, sel_up;

    // first pending pixel at or after rr_q, wrapping
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 0; k < N_PIX; k++) begin
            idx = rr_q + PIX_AW'(k);
            if (!gnt_any && !fifo_full && pend_q[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    assign fifo_wr    = gnt_any;
    assign fifo_wdata = {toa_q[gnt_idx], ftoa_q[gnt_idx], tot_q[gnt_idx],
                         gnt_idx, col_addr};

    // a pixel freed by this cycle's grant may reload in the same cycle
    always_comb begin
        pend_d = pend_q;
        toa_d  = toa_q;
        ftoa_d = ftoa_q;
        tot_d  = tot_q;
        rr_d   = rr_q;
        ndrop  = '0;
        if (gnt_any) begin
            pend_d[gnt_idx] = 1'b0;
            rr_d            = gnt_idx + PIX_AW'(1);
        end
        for (int i = 0; i < N_PIX; i++) begin
            if (en && hit_valid[i]) begin
                if (pend_d[i]) begin
                    ndrop = ndrop + 16'd1;
                end else begin
                    pend_d[i] = 1'b1;
                    toa_d[i]  = (TOA_GRAY_DEC != 0)
                        ? TOA_W'(gray2bin(32'(hit_toa[i*TOA_W +: TOA_W])))
                        : hit_toa[i*TOA_W +: TOA_W];
                    ftoa_d[i] = hit_ftoa[i*FTOA_W +: FTOA_W];
                    tot_d[i]  = hit_tot[i*TOT_W +: TOT_W];
                end
            end
        end
        ovf_sum = 16'(ovf_q) + ndrop;
        ovf_d   = (ovf_sum > 16'd255) ? 8'hFF : ovf_sum[7:0];
    end

    always_comb begin
        load_en     = !out_valid_q || out_ready;
        sel_loc     = load_en && !fifo_empty
                      && (!last_valid || prio_loc_q);
        sel_up      = load_en && last_valid
                      && (fifo_empty || !prio_loc_q);
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        prio_loc_d  = prio_loc_q;
        if (load_en) out_valid_d = sel_loc || sel_up;
        if (sel_loc) begin
            out_data_d = fifo_rdata;
        end else if (sel_up) begin
            out_data_d = last_data;
        end
        if (load_en && !fifo_empty && last_valid) prio_loc_d = !prio_loc_q;
    end

    assign fifo_rd    = sel_loc;
    assign last_ready = sel_up && !rst;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign ovf_cnt    = ovf_q;
    assign busy       = (|pend_q) || !fifo_empty || out_valid_q;

    always_ff @(posedge clk_40MHz or posedge rst) begin
        if (rst) begin
            pend_q      <= '0;
            rr_q        <= '0;
            ovf_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            prio_loc_q  <= 1'b1;
        end else begin
            pend_q      <= pend_d;
            rr_q        <= rr_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            prio_loc_q  <= prio_loc_d;
        end
    end

    always_ff @(posedge clk_40MHz) begin
        toa_q  <= toa_d;
        ftoa_q <= ftoa_d;
        tot_q  <= tot_d;
    end

    sp_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk_40MHz),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

endmodule
